tx_pulser_ch: RTL and testbench

Per-channel transmit beamforming pulser, the transmit-side counterpart of the per-channel receive DBF path. On a global transmit trigger it looks up the channel's focusing delay for the selected scan line, waits that many clocks, then emits a bipolar burst (pulse_p/pulse_n) to the HV pulser driver. It also drives tx_en, which gates the receive channel's coarse-delay input valid.

---
 rtl/tx_pulser_ch_pkg.sv | 19 +
 rtl/tx_delay_lut.sv | 31 +++
 rtl/tx_pulser_ch.sv | 158 +++++++++++++++
 tb/tb_tx_pulser_ch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pulser_ch_pkg.sv
// Shared definitions for the per-channel transmit pulser.
//   - Default widths, kept in step with the receive DBF parameter set.
//   - FSM state encoding for tx_pulser_ch.
package tx_pulser_ch_pkg;

  localparam int DEF_ADDR_WD = 8;   // scan-line delay LUT address width
  localparam int DEF_DLY_WD  = 12;  // transmit delay width (clk cycles)
  localparam int DEF_HALF_WD = 6;   // burst half-period width (clk cycles)
  localparam int DEF_CYC_WD  = 5;   // burst cycle-count width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_delay_lut.sv
// Per-channel focusing delay table: one write port, one registered read port.
// A write and a read to the same address in one cycle returns the old data.
// Ports:
//   clk          system clock
//   we/waddr/wdata  write port
//   re/raddr     read request; rdata is valid the cycle after re
//   rdata        registered read data
module tx_delay_lut
  import tx_pulser_ch_pkg::*;
#(
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DLY_WD  = DEF_DLY_WD
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DLY_WD-1:0]  wdata,
  input  logic               re,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DLY_WD-1:0]  rdata
);

  logic [DLY_WD-1:0] mem [2**ADDR_WD];

  // Both accesses in one non-blocking block: the read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tx_pulser_ch.sv
// Per-channel transmit beamforming pulser.
// On an accepted trigger, looks up the focusing delay for line_sel, waits that
// many clocks, then emits num_cycles bipolar cycles on pulse_p/pulse_n with
// half_period clocks per phase.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   lut_addr/lut_we/lut_wdata  delay LUT write port
//   line_sel, half_period, num_cycles  firing parameters, captured on trigger
//   ch_en                      0 = channel silent (trigger ignored)
//   tx_trig                    single-cycle fire request
//   abort                      synchronous abort of the current firing
//   pulse_p, pulse_n           registered bipolar drive
//   tx_en                      high from LOAD through the last pulse cycle
//   busy                       high whenever not IDLE
//   done                       one-cycle pulse on normal completion
module tx_pulser_ch
  import tx_pulser_ch_pkg::*;
#(
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DLY_WD  = DEF_DLY_WD,
  parameter int HALF_WD = DEF_HALF_WD,
  parameter int CYC_WD  = DEF_CYC_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_WD-1:0] lut_addr,
  input  logic               lut_we,
  input  logic [DLY_WD-1:0]  lut_wdata,
  input  logic [ADDR_WD-1:0] line_sel,
  input  logic [HALF_WD-1:0] half_period,
  input  logic [CYC_WD-1:0]  num_cycles,
  input  logic               ch_en,
  input  logic               tx_trig,
  input  logic               abort,
  output logic               pulse_p,
  output logic               pulse_n,
  output logic               tx_en,
  output logic               busy,
  output logic               done
);

  tx_state_e          state;
  logic [DLY_WD-1:0]  dly_cnt;
  logic [HALF_WD-1:0] half_len;
  logic [HALF_WD-1:0] half_cnt;
  logic [CYC_WD-1:0]  cyc_cnt;
  logic               ph_n;      // next phase to start is the negative one
  logic               trig_acc;
  logic [DLY_WD-1:0]  lut_rdata;

  always_comb begin
    trig_acc = 1'b0;
    trig_acc = (state == ST_IDLE) && tx_trig && ch_en && !abort;
  end

  tx_delay_lut #(
    .ADDR_WD (ADDR_WD),
    .DLY_WD  (DLY_WD)
  ) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .re    (trig_acc),
    .raddr (line_sel),
    .rdata (lut_rdata)
  );

  // PULSE opens with one lead cycle (half_cnt=0, ph_n=0) before the first
  // phase; this is what places the first pulse_p two clocks plus D after the
  // trigger, and lets N=0 leave through the same cycle-count test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dly_cnt  <= '0;
      half_len <= '0;
      half_cnt <= '0;
      cyc_cnt  <= '0;
      ph_n     <= 1'b0;
      pulse_p  <= 1'b0;
      pulse_n  <= 1'b0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state   <= ST_IDLE;
      pulse_p <= 1'b0;
      pulse_n <= 1'b0;
      tx_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (trig_acc) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            tx_en    <= 1'b1;
            half_len <= (half_period == '0) ? HALF_WD'(1) : half_period;
            cyc_cnt  <= num_cycles;
          end
        end
        ST_LOAD: begin
          dly_cnt <= lut_rdata;
          if (lut_rdata == '0) begin
            state    <= ST_PULSE;
            half_cnt <= '0;
            ph_n     <= 1'b0;
          end else begin
            state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          dly_cnt <= dly_cnt - DLY_WD'(1);
          if (dly_cnt == DLY_WD'(1)) begin
            state    <= ST_PULSE;
            half_cnt <= '0;
            ph_n     <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - HALF_WD'(1);
          end else if (ph_n) begin
            pulse_p  <= 1'b0;
            pulse_n  <= 1'b1;
            half_cnt <= half_len - HALF_WD'(1);
            ph_n     <= 1'b0;
          end else if (cyc_cnt != '0) begin
            pulse_n  <= 1'b0;
            pulse_p  <= 1'b1;
            half_cnt <= half_len - HALF_WD'(1);
            ph_n     <= 1'b1;
            cyc_cnt  <= cyc_cnt - CYC_WD'(1);
          end else begin
            pulse_p <= 1'b0;
            pulse_n <= 1'b0;
            tx_en   <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pulser_ch.sv
`timescale 1ns/1ps
module tb_tx_pulser_ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lut_addr;
  logic       lut_we;
  logic [11:0] lut_wdata;
  logic [7:0] line_sel;
  logic [5:0] half_period;
  logic [4:0] num_cycles;
  logic       ch_en;
  logic       tx_trig;
  logic       abort;
  logic       pulse_p, pulse_n, tx_en, busy, done;

  int errors = 0;
  int checks = 0;
  int lut_m [256];

  always #5 clk = ~clk;

  tx_pulser_ch #(
    .ADDR_WD (8),
    .DLY_WD  (12),
    .HALF_WD (6),
    .CYC_WD  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lut_addr    (lut_addr),
    .lut_we      (lut_we),
    .lut_wdata   (lut_wdata),
    .line_sel    (line_sel),
    .half_period (half_period),
    .num_cycles  (num_cycles),
    .ch_en       (ch_en),
    .tx_trig     (tx_trig),
    .abort       (abort),
    .pulse_p     (pulse_p),
    .pulse_n     (pulse_n),
    .tx_en       (tx_en),
    .busy        (busy),
    .done        (done)
  );

  // Reference: outputs {busy,tx_en,pulse_p,pulse_n,done} t cycles after the
  // trigger edge, for delay d, half-period h and n cycles.
  function automatic logic [4:0] model(int t, int d, int h, int n);
    logic b, e, p, q, dn;
    int last, r;
    last = 2 + d + 2 * h * n;
    b  = (t >= 0) && (t <= last);
    e  = (t >= 0) && (t < last);
    dn = (t == last);
    p  = 1'b0;
    q  = 1'b0;
    if (t >= 2 + d && t < last) begin
      r = (t - 2 - d) % (2 * h);
      p = (r < h);
      q = (r >= h);
    end
    return {b, e, p, q, dn};
  endfunction

  function automatic logic [4:0] outs();
    return {busy, tx_en, pulse_p, pulse_n, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input int addr, input int data);
    lut_addr  = 8'(addr);
    lut_wdata = 12'(data);
    lut_we    = 1'b1;
    step();
    lut_we    = 1'b0;
    lut_m[addr] = data;
  endtask

  // Fires one trigger and checks every cycle through the return to IDLE.
  // noise: scramble the firing inputs and re-trigger while busy.
  // cwe: perform a LUT write on the trigger edge itself.
  task automatic fire(input string name, input int line, input int hp, input int nc,
                      input bit en, input bit noise, input bit cwe, input int caddr,
                      input int cdata);
    int d, h, last, tend;
    logic [4:0] exp_v, got;
    d = lut_m[line];
    h = (hp == 0) ? 1 : hp;
    last = 2 + d + 2 * h * nc;
    tend = en ? last + 2 : 8;
    line_sel    = 8'(line);
    half_period = 6'(hp);
    num_cycles  = 5'(nc);
    ch_en       = en;
    tx_trig     = 1'b1;
    if (cwe) begin
      lut_addr  = 8'(caddr);
      lut_wdata = 12'(cdata);
      lut_we    = 1'b1;
    end
    step();
    tx_trig = 1'b0;
    lut_we  = 1'b0;
    if (cwe) lut_m[caddr] = cdata;
    for (int t = 0; t <= tend; t++) begin
      exp_v = en ? model(t, d, h, nc) : 5'b0;
      got   = outs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0d {busy,tx_en,p,n,done} got=%b exp=%b", name, t, got, exp_v);
      end
      if (noise && en && t + 1 <= last + 1) begin
        line_sel    = 8'($urandom);
        half_period = 6'($urandom);
        num_cycles  = 5'($urandom);
        tx_trig     = ($urandom_range(0, 3) == 0);
      end else begin
        tx_trig = 1'b0;
      end
      step();
    end
    tx_trig = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL after_reset_idle got=%b exp=%b", outs(), 5'b0);
    end
  endtask

  task automatic test_basic();
    lut_write(3, 5);
    fire("basic", 3, 2, 2, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_zero_delay();
    lut_write(0, 0);
    fire("zero_delay", 0, 0, 1, 1'b1, 1'b0, 1'b0, 0, 0);
    lut_write(7, 4);
    fire("n_zero", 7, 3, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    fire("n_zero_d0", 0, 1, 0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_ch_en_off();
    fire("ch_en_off", 3, 2, 2, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    fire("retrig_busy", 3, 2, 2, 1'b1, 1'b1, 1'b0, 0, 0);
    fire("back_to_back", 0, 1, 2, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_abort();
    int d, tp;
    logic [4:0] got;
    d  = lut_m[3];
    tp = 2 + d + 4;  // first cycle of the second pulse_p phase (H=2)
    line_sel = 8'd3; half_period = 6'd2; num_cycles = 5'd2; ch_en = 1'b1;
    tx_trig = 1'b1;
    step();
    tx_trig = 1'b0;
    for (int t = 0; t <= tp; t++) begin
      checks++;
      if (outs() !== model(t, d, 2, 2)) begin
        errors++;
        $display("FAIL abort_pre t=%0d got=%b exp=%b", t, outs(), model(t, d, 2, 2));
      end
      if (t < tp) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int t = 0; t < 20; t++) begin
      got = outs();
      checks++;
      if (got !== 5'b0) begin
        errors++;
        $display("FAIL abort_post t=%0d got=%b exp=%b", t, got, 5'b0);
      end
      step();
    end
    abort = 1'b1;
    tx_trig = 1'b1;
    step();
    abort = 1'b0;
    tx_trig = 1'b0;
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (outs() !== 5'b0) begin
        errors++;
        $display("FAIL abort_trig_idle t=%0d got=%b exp=%b", t, outs(), 5'b0);
      end
      step();
    end
  endtask

  task automatic test_collision();
    lut_write(3, 5);
    fire("collision_old", 3, 1, 1, 1'b1, 1'b0, 1'b1, 3, 9);
    fire("collision_new", 3, 1, 1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_param_hold();
    lut_write(20, 2);
    fire("param_hold", 20, 3, 3, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int d;
    d = lut_m[3];
    line_sel = 8'd3; half_period = 6'd2; num_cycles = 5'd2; ch_en = 1'b1;
    tx_trig = 1'b1;
    step();
    tx_trig = 1'b0;
    for (int t = 0; t < 2 + d + 1; t++) step();
    checks++;
    if (outs() !== model(2 + d + 1, d, 2, 2)) begin
      errors++;
      $display("FAIL reset_mid_pre got=%b exp=%b", outs(), model(2 + d + 1, d, 2, 2));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", outs(), 5'b0);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy got=%b exp=%b", busy, 1'b0);
    end
    fire("after_reset_mid", 3, 2, 2, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int line, hp, nc;
    bit en;
    for (int i = 0; i < 12; i++) begin
      line = $urandom_range(0, 255);
      lut_write(line, $urandom_range(0, 30));
      hp = $urandom_range(0, 4);
      nc = $urandom_range(0, 3);
      en = ($urandom_range(0, 5) != 0);
      fire("random", line, hp, nc, en, 1'b1, 1'b0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; lut_addr = '0; lut_we = 1'b0; lut_wdata = '0;
    line_sel = '0; half_period = '0; num_cycles = '0;
    ch_en = 1'b0; tx_trig = 1'b0; abort = 1'b0;
    for (int i = 0; i < 256; i++) lut_m[i] = 0;
    test_reset();
    test_basic();
    test_zero_delay();
    test_ch_en_off();
    test_back_to_back();
    test_abort();
    test_collision();
    test_param_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
